port_arbiter: RTL and testbench
===============================

PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 5, meaning the number of requesting input ports, with index REQ_NUM-1 as the local IP port.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning the stall-cycle limit used only when ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk  input  1  meaning the single clock, rising-edge.
REQ-004 SHALL have port a_rst  input  1  meaning reset, which is synchronous and active-high, sampled on the clk rising edge.
REQ-005 SHALL have port req_i  input  REQ_NUM  meaning requester i holds a flit for this output.
REQ-006 SHALL have port tail_i  input  REQ_NUM  meaning the head flit of requester i is the last flit of its packet.
REQ-007 SHALL have port out_ready_i  input  1  meaning the downstream write-ready: the output can accept a flit this cycle.
REQ-008 SHALL have port grant_o  output  REQ_NUM  meaning a one-hot registered grant.
REQ-009 SHALL have port owner_o  output  clog2(REQ_NUM)  meaning the index of the granted requester, valid while busy_o=1.
REQ-010 SHALL have port busy_o  output  1  meaning the output is locked to an owner.
REQ-011 SHALL have port xfer_o  output  1  meaning a flit is transferred this cycle (combinational).
REQ-012 SHALL have port pkt_cnt_o  output  32  meaning the count of completed packets.
REQ-013 SHALL have port timeout_o  output  1  meaning a one-cycle pulse on forced release.

Function
REQ-014 SHALL implement two states: IDLE and LOCKED.
REQ-015 In IDLE with any req_i set, SHALL select the winner round-robin, searching from index ptr+1 upward with wrap, and SHALL register grant_o, owner_o, and busy_o=1 on the next edge (1-cycle arbitration latency).
REQ-016 In IDLE with req_i=0, SHALL remain in IDLE with grant_o=0.
REQ-017 SHALL define xfer_o = busy_o & req_i[owner_o] & out_ready_i, which SHALL be 0 in IDLE.
REQ-018 In LOCKED on xfer_o with tail_i[owner_o]=1, SHALL go to IDLE, clear grant_o, set ptr=owner_o, and increment pkt_cnt_o by 1.
REQ-019 In LOCKED on xfer_o with tail_i[owner_o]=0, SHALL stay LOCKED (wormhole hold).
REQ-020 SHALL ignore requests from non-owners while LOCKED; the owner cannot be changed mid-packet.
REQ-021 SHALL ensure a single-flit packet (tail on the first flit) occupies 2 cycles: 1 arbitration cycle plus 1 transfer cycle.
REQ-022 When out_ready_i=0, SHALL hold state, grant, and counters unchanged.
REQ-023 SHALL let pkt_cnt_o wrap from 2^32-1 to 0 with no saturation.
REQ-024 SHALL keep grant_o always one-hot or zero, never multi-hot.

Reset
REQ-025 SHALL, while a_rst=1 at a clk edge, force state=IDLE, grant_o=0, owner_o=0, busy_o=0, pkt_cnt_o=0, timeout_o=0, stall counter=0, and ptr=REQ_NUM-1 (so index 0 wins first).
REQ-026 SHALL abandon any packet in progress on a reset asserted mid-packet, without incrementing pkt_cnt_o.
REQ-027 SHALL accept no arbitration while a_rst=1, and SHALL perform the first arbitration on the first edge after deassertion.

Configuration
REQ-028 With ARB_TIMEOUT_EN defined, SHALL count consecutive LOCKED cycles where req_i[owner_o]=0; when the count reaches TIMEOUT it SHALL go to IDLE, set ptr=owner_o, pulse timeout_o for 1 cycle, and leave pkt_cnt_o unincremented. The counter SHALL clear on any cycle with req_i[owner_o]=1 and on leaving LOCKED.
REQ-029 Without ARB_TIMEOUT_EN, SHALL hold the lock indefinitely, tie timeout_o to 0, and omit the stall counter.

Verification
REQ-030 Reset, then req_i=5'b00001 with tail_i=1 and out_ready_i=1 -> grant_o=00001 on cycle 1, xfer_o=1 on cycle 1, pkt_cnt_o=1 and busy_o=0 on cycle 2.
REQ-031 req_i=5'b10101 held, every flit a tail -> grant order 0,2,4,0,2; pkt_cnt_o=5 after 10 cycles.
REQ-032 Owner 1 sends a 4-flit packet (tail on flit 4) while req_i[3]=1 throughout -> grant stays 00010 for 4 transfers, then 01000 one cycle later.
REQ-033 out_ready_i=0 for 3 cycles mid-packet -> xfer_o=0, grant_o and pkt_cnt_o unchanged, transfer resumes when out_ready_i=1.
REQ-034 a_rst=1 after flit 2 of a 4-flit packet -> busy_o=0, pkt_cnt_o=0, next grant goes to lowest-index requester.
REQ-035 ARB_TIMEOUT_EN with TIMEOUT=16: owner drops req for 16 cycles -> timeout_o pulses on cycle 16, busy_o=0, pkt_cnt_o unchanged; without the macro, busy_o stays 1.

Source files
------------

// File: rtl/port_arbiter.sv
// ---------------------------------------------------------------------------
// port_arbiter
//    Wormhole output-port arbiter. Requesters compete round-robin for a
//    single output. Once a requester wins, the output stays locked to it
//    until the tail flit is transferred, so packets are never interleaved.
//
//    Optional feature: define ARB_TIMEOUT_EN to release the lock after the
//    owner has been silent (req low) for TIMEOUT consecutive locked cycles.
//
// Parameters
//    REQ_NUM  number of requesters; index REQ_NUM-1 is the local IP port
//    TIMEOUT  stall-cycle limit (only used with ARB_TIMEOUT_EN)
//
// Ports
//    clk          clock, rising edge
//    a_rst        synchronous active-high reset
//    req_i        per-requester "holding a flit for this output"
//    tail_i       per-requester "head flit is the packet tail"
//    out_ready_i  downstream can accept a flit this cycle
//    grant_o      registered one-hot grant (zero when idle)
//    owner_o      index of the current owner, valid while busy_o=1
//    busy_o       output is locked to an owner
//    xfer_o       a flit moves this cycle (combinational)
//    pkt_cnt_o    completed-packet counter, wraps at 2^32
//    timeout_o    one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module port_arbiter #(
   parameter int  REQ_NUM = 5,
   parameter int  TIMEOUT = 16,
   localparam int OW      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
   input  logic               clk,
   input  logic               a_rst,
   input  logic [REQ_NUM-1:0] req_i,
   input  logic [REQ_NUM-1:0] tail_i,
   input  logic               out_ready_i,
   output logic [REQ_NUM-1:0] grant_o,
   output logic [OW-1:0]      owner_o,
   output logic               busy_o,
   output logic               xfer_o,
   output logic [31:0]        pkt_cnt_o,
   output logic               timeout_o
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t             state_r, state_n;
   logic [REQ_NUM-1:0] grant_r, grant_n;
   logic [OW-1:0]      owner_r, owner_n;
   logic [OW-1:0]      ptr_r, ptr_n;
   logic [31:0]        pkt_r, pkt_n;
   logic               rr_found_s;
   logic [OW-1:0]      rr_win_s;
   logic               xfer_s;

`ifdef ARB_TIMEOUT_EN
   localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   logic [SW-1:0] stall_r, stall_n;
   logic          tmo_r, tmo_n;
`endif

   // Round-robin search: first requester after ptr_r, wrapping around.
   always_comb begin
      rr_found_s = 1'b0;
      rr_win_s   = '0;
      for (int k = 1; k <= REQ_NUM; k++) begin
         logic [OW-1:0] idx_v;
         idx_v = OW'((int'(ptr_r) + k) % REQ_NUM);
         if (!rr_found_s && req_i[idx_v]) begin
            rr_found_s = 1'b1;
            rr_win_s   = idx_v;
         end else begin
            rr_found_s = rr_found_s;
         end
      end
   end

   // A flit moves only when locked, the owner has a flit and downstream is ready.
   always_comb begin
      xfer_s = (state_r == LOCKED) & req_i[owner_r] & out_ready_i;
   end

   // Next-state and next-output logic for the IDLE/LOCKED machine.
   always_comb begin
      state_n = state_r;
      grant_n = grant_r;
      owner_n = owner_r;
      ptr_n   = ptr_r;
      pkt_n   = pkt_r;
`ifdef ARB_TIMEOUT_EN
      stall_n = stall_r;
      tmo_n   = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            if (rr_found_s) begin
               state_n = LOCKED;
               owner_n = rr_win_s;
               grant_n = {{(REQ_NUM-1){1'b0}}, 1'b1} << rr_win_s;
            end else begin
               grant_n = '0;
            end
         end
         LOCKED: begin
            if (xfer_s && tail_i[owner_r]) begin
               // Tail accepted: release and make this owner lowest priority.
               state_n = IDLE;
               grant_n = '0;
               ptr_n   = owner_r;
               pkt_n   = pkt_r + 32'd1;
`ifdef ARB_TIMEOUT_EN
               stall_n = '0;
`endif
            end else begin
`ifdef ARB_TIMEOUT_EN
               // The stall count only runs while the owner has no flit.
               if (req_i[owner_r]) begin
                  stall_n = '0;
               end else if (stall_r == SW'(TIMEOUT - 1)) begin
                  state_n = IDLE;
                  grant_n = '0;
                  ptr_n   = owner_r;
                  stall_n = '0;
                  tmo_n   = 1'b1;
               end else begin
                  stall_n = stall_r + SW'(1);
               end
`else
               state_n = LOCKED;
`endif
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (a_rst) begin
         state_r <= IDLE;
         grant_r <= '0;
         owner_r <= '0;
         ptr_r   <= OW'(REQ_NUM - 1);
         pkt_r   <= 32'd0;
      end else begin
         state_r <= state_n;
         grant_r <= grant_n;
         owner_r <= owner_n;
         ptr_r   <= ptr_n;
         pkt_r   <= pkt_n;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Stall counter and timeout pulse registers.
   always_ff @(posedge clk) begin
      if (a_rst) begin
         stall_r <= '0;
         tmo_r   <= 1'b0;
      end else begin
         stall_r <= stall_n;
         tmo_r   <= tmo_n;
      end
   end

   assign timeout_o = tmo_r;
`else
   assign timeout_o = 1'b0;
`endif

   assign grant_o   = grant_r;
   assign owner_o   = owner_r;
   assign busy_o    = (state_r == LOCKED);
   assign xfer_o    = xfer_s;
   assign pkt_cnt_o = pkt_r;

endmodule

// File: tb/tb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_port_arbiter
//    Scoreboard bench for port_arbiter. The driver applies inputs on the
//    falling edge, steps a packet-level reference model and queues the
//    expected xfer for the current cycle and the expected registered
//    outputs after the next rising edge. Two monitors pop and compare.
// ---------------------------------------------------------------------------
module tb_port_arbiter;

   localparam int N  = 5;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         a_rst = 1'b1;
   logic [N-1:0] req_i = '0;
   logic [N-1:0] tail_i = '0;
   logic         out_ready_i = 1'b0;
   logic [N-1:0] grant_o;
   logic [2:0]   owner_o;
   logic         busy_o;
   logic         xfer_o;
   logic [31:0]  pkt_cnt_o;
   logic         timeout_o;

   int n_checks = 0;
   int n_fail   = 0;

   port_arbiter #(.REQ_NUM(N), .TIMEOUT(TO)) dut (
      .clk(clk), .a_rst(a_rst), .req_i(req_i), .tail_i(tail_i),
      .out_ready_i(out_ready_i), .grant_o(grant_o), .owner_o(owner_o),
      .busy_o(busy_o), .xfer_o(xfer_o), .pkt_cnt_o(pkt_cnt_o),
      .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] grant;
      int           owner;
      logic         busy;
      logic [31:0]  pkt;
      logic         tmo;
   } exp_t;

   exp_t exp_q[$];
   logic xfer_q[$];

   // Reference model: who owns the output, who was served last, packets done.
   bit          m_valid  = 1'b0;
   bit          m_locked = 1'b0;
   int          m_owner  = 0;
   int          m_last   = N - 1;
   int unsigned m_pkt    = 0;
   int          m_stall  = 0;
   bit          m_tmo    = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
      end
   endtask

   task automatic model_step(input logic [N-1:0] rq, input logic [N-1:0] tl,
                             input logic rdy, input logic rst);
      exp_t e;
      if (rst) begin
         m_locked = 1'b0; m_owner = 0; m_last = N - 1;
         m_pkt = 0; m_stall = 0; m_tmo = 1'b0; m_valid = 1'b1;
      end else begin
         m_tmo = 1'b0;
         if (!m_locked) begin
            // next requester after the last one served, wrapping
            for (int k = 1; k <= N; k++) begin
               if (!m_locked && rq[(m_last + k) % N]) begin
                  m_locked = 1'b1;
                  m_owner  = (m_last + k) % N;
               end
            end
         end else if (rq[m_owner] && rdy && tl[m_owner]) begin
            m_locked = 1'b0; m_last = m_owner; m_pkt++; m_stall = 0;
         end else begin
`ifdef ARB_TIMEOUT_EN
            if (rq[m_owner]) m_stall = 0;
            else begin
               m_stall++;
               if (m_stall == TO) begin
                  m_locked = 1'b0; m_last = m_owner; m_stall = 0; m_tmo = 1'b1;
               end
            end
`endif
         end
      end
      e.grant = m_locked ? (N'(1) << m_owner) : '0;
      e.owner = m_owner;
      e.busy  = m_locked;
      e.pkt   = m_pkt;
      e.tmo   = m_tmo;
      exp_q.push_back(e);
   endtask

   // One clock cycle of stimulus plus its expectations.
   task automatic cyc(input logic [N-1:0] rq, input logic [N-1:0] tl,
                      input logic rdy, input logic rst);
      @(negedge clk);
      req_i = rq; tail_i = tl; out_ready_i = rdy; a_rst = rst;
      if (m_valid && !rst) xfer_q.push_back(m_locked && rq[m_owner] && rdy);
      model_step(rq, tl, rdy, rst);
   endtask

   // Monitor for the combinational transfer strobe, mid low phase.
   always @(negedge clk) begin
      #2;
      if (xfer_q.size() > 0) chk("xfer", 32'(xfer_o), 32'(xfer_q.pop_front()));
   end

   // Monitor for the registered outputs just after the rising edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("grant",   32'(grant_o),   32'(e.grant));
         chk("busy",    32'(busy_o),    32'(e.busy));
         chk("pkt_cnt", pkt_cnt_o,      e.pkt);
         chk("timeout", 32'(timeout_o), 32'(e.tmo));
         if (e.busy) chk("owner", 32'(owner_o), 32'(e.owner));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
      $fatal(1);
   end

   initial begin
      // reset, then a single one-flit packet from requester 0
      cyc(5'b00000, 5'b00000, 1'b0, 1'b1);
      cyc(5'b00000, 5'b00000, 1'b0, 1'b1);
      cyc(5'b00001, 5'b11111, 1'b1, 1'b0);
      cyc(5'b00001, 5'b11111, 1'b1, 1'b0);
      cyc(5'b00000, 5'b00000, 1'b1, 1'b0);

      // three requesters, single-flit packets: order 0,2,4,0,2
      cyc(5'b00000, 5'b00000, 1'b1, 1'b1);
      repeat (10) cyc(5'b10101, 5'b11111, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("pkt_after_10", pkt_cnt_o, 32'd5);

      // 4-flit packet from 1 with 3 waiting, plus a 3-cycle ready stall
      cyc(5'b00000, 5'b00000, 1'b1, 1'b1);
      cyc(5'b01010, 5'b00000, 1'b1, 1'b0);
      cyc(5'b01010, 5'b00000, 1'b1, 1'b0);
      cyc(5'b01010, 5'b00000, 1'b1, 1'b0);
      repeat (3) cyc(5'b01010, 5'b00010, 1'b0, 1'b0);
      cyc(5'b01010, 5'b00000, 1'b1, 1'b0);
      cyc(5'b01010, 5'b00010, 1'b1, 1'b0);
      cyc(5'b01000, 5'b00000, 1'b1, 1'b0);
      cyc(5'b01000, 5'b01000, 1'b1, 1'b0);

      // reset in the middle of a packet, then lowest index wins
      cyc(5'b00100, 5'b00000, 1'b1, 1'b0);
      cyc(5'b00100, 5'b00000, 1'b1, 1'b0);
      cyc(5'b00100, 5'b00000, 1'b1, 1'b0);
      cyc(5'b00100, 5'b00000, 1'b1, 1'b1);
      cyc(5'b11110, 5'b00000, 1'b1, 1'b0);
      cyc(5'b11110, 5'b11110, 1'b1, 1'b0);

      // owner goes silent long enough to trip the timeout if enabled
      cyc(5'b00000, 5'b00000, 1'b1, 1'b1);
      cyc(5'b00001, 5'b00000, 1'b1, 1'b0);
      repeat (20) cyc(5'b00000, 5'b00000, 1'b1, 1'b0);
      cyc(5'b00001, 5'b00001, 1'b1, 1'b0);
      cyc(5'b00001, 5'b00001, 1'b1, 1'b0);

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         logic [N-1:0] rq, tl;
         logic         rdy, rst;
         rq  = N'($urandom_range(0, 31));
         tl  = N'($urandom_range(0, 31)) & N'($urandom_range(0, 31));
         rdy = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 299) == 0);
         cyc(rq, tl, rdy, rst);
      end

      repeat (3) @(posedge clk);
      #3;
      if (exp_q.size() != 0 || xfer_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size() + xfer_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
